// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data memory answering one request at a time after a fixed latency,
// returning a single-cycle response and committing byte-masked writes on the way out of RESP.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h1ECE_B000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic        dmem_err,
  output logic        busy,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic [29:0] addr_w;
  logic [3:0]  rmask, wmask;
  logic [31:0] wdata;
  logic [31:0] mem [DEPTH_WORDS];
  logic [29:0] off;
  logic        req, err, unused_ok;
  assign unused_ok = &{1'b0, dmem_addr[1:0]};
  assign req = |{dmem_rmask, dmem_wmask};
  // unsigned word offset also catches addresses below the base, which wrap to huge values
  assign off = addr_w - BASE_ADDR[31:2];
  assign err = (off >= 30'(DEPTH_WORDS)) || (|rmask && |wmask);
  always_comb begin
    state_nx = IDLE;
    if (state == IDLE)
      state_nx = req ? (LATENCY == 1 ? RESP : WAIT) : IDLE;
    else if (state == WAIT)
      state_nx = cnt == 4'd1 ? RESP : WAIT;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_w <= '0;
      rmask  <= '0;
      wmask  <= '0;
      wdata  <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req) begin
        addr_w <= dmem_addr[31:2];
        rmask  <= dmem_rmask;
        wmask  <= dmem_wmask;
        wdata  <= dmem_wdata;
        cnt    <= 4'(LATENCY - 1);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (state == RESP && !err) begin
        rd_cnt <= rd_cnt + 32'(|rmask);
        wr_cnt <= wr_cnt + 32'(|wmask);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (state == RESP && !err)
      for (int i = 0; i < 4; i++)
        if (wmask[i]) mem[off[AW-1:0]][8*i +: 8] <= wdata[8*i +: 8];
  end
  assign dmem_resp  = state == RESP;
  assign busy       = state != IDLE;
  assign dmem_err   = dmem_resp && err;
  assign dmem_rdata = (dmem_resp && !err) ? mem[off[AW-1:0]] : '0;
endmodule
